// File: rtl/poly_sweep_ctrl.sv
// rtl/poly_sweep_ctrl.sv - sweep driver and result collector for the polynomial evaluator stream
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   i_start               start a sweep (accepted only in IDLE or DONE)
//   i_x_start, i_x_step   first x sample and increment, Q2.14, latched on start
//   i_count               number of samples N, latched on start
//   i_stall               host backpressure; drops o_rx_ready while busy
//   o_x, o_x_valid        sample stream toward the evaluator
//   i_dut_ready           evaluator input ready
//   o_rx_ready            ready toward the evaluator result port
//   i_y, i_y_valid        Q7.25 results from the evaluator
//   o_busy, o_done        RUN/DRAIN and DONE status
//   o_timeout             sticky: sweep ended because results stopped arriving
//   o_rcvd, o_sum         result count and wrap-around sum of results
//   o_last_y              most recently received result

module poly_sweep_ctrl #(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32,
  parameter int CNTW     = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [WIDTHIN-1:0]  i_x_start,
  input  logic [WIDTHIN-1:0]  i_x_step,
  input  logic [CNTW-1:0]     i_count,
  input  logic                i_stall,
  output logic [WIDTHIN-1:0]  o_x,
  output logic                o_x_valid,
  input  logic                i_dut_ready,
  output logic                o_rx_ready,
  input  logic [WIDTHOUT-1:0] i_y,
  input  logic                i_y_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [CNTW-1:0]     o_rcvd,
  output logic [WIDTHOUT-1:0] o_sum,
  output logic [WIDTHOUT-1:0] o_last_y
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTHIN-1:0] x_step_q;
  logic [CNTW-1:0]    count_q;
  logic [CNTW-1:0]    issued;
  logic [TW-1:0]      tmo_cnt;

  logic               active;
  logic               start_acc;
  logic               xfer;
  logic               rx;
  logic [CNTW-1:0]    issued_inc;
  logic [CNTW-1:0]    rcvd_inc;
  logic [TW-1:0]      tmo_inc;
  logic               last_issue;
  logic               all_rcvd;
  logic               tmo_hit;

  assign active     = (state == S_RUN) || (state == S_DRAIN);
  assign start_acc  = ((state == S_IDLE) || (state == S_DONE)) && i_start;
  assign xfer       = (state == S_RUN) && i_dut_ready;
  assign rx         = active && i_y_valid;
  assign issued_inc = issued + 1'b1;
  assign rcvd_inc   = o_rcvd + CNTW'(rx);
  assign tmo_inc    = tmo_cnt + 1'b1;
  assign last_issue = xfer && (issued_inc == count_q);
  // Compared against the post-update count so a result landing this cycle
  // finishes the sweep; >= keeps a surplus result from stranding DRAIN.
  assign all_rcvd   = (rcvd_inc >= count_q);
  // Idle DRAIN cycle that would push the counter to the limit. A result on
  // the same cycle makes i_y_valid high, so a final result always wins.
  assign tmo_hit    = (state == S_DRAIN) && !i_y_valid && !i_stall &&
                      (tmo_inc == TW'(TIMEOUT));

  assign o_x_valid  = (state == S_RUN);
  assign o_busy     = active;
  assign o_done     = (state == S_DONE);
  // The evaluator's input ready follows this signal, so a host stall also
  // freezes sample issue.
  assign o_rx_ready = active && !i_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_nxt = (i_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (all_rcvd || tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_step_q  <= '0;
      count_q   <= '0;
      issued    <= '0;
      tmo_cnt   <= '0;
      o_x       <= '0;
      o_rcvd    <= '0;
      o_sum     <= '0;
      o_last_y  <= '0;
      o_timeout <= 1'b0;
    end else if (start_acc) begin
      x_step_q  <= i_x_step;
      count_q   <= i_count;
      issued    <= '0;
      tmo_cnt   <= '0;
      o_x       <= i_x_start;
      o_rcvd    <= '0;
      o_sum     <= '0;
      o_last_y  <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (xfer) begin
        issued <= issued_inc;
        o_x    <= o_x + x_step_q;
      end
      if (rx) begin
        o_rcvd   <= rcvd_inc;
        o_sum    <= o_sum + i_y;
        o_last_y <= i_y;
      end
      // Stalled cycles hold the counter so backpressure never times out.
      if (rx) begin
        tmo_cnt <= '0;
      end else if ((state == S_DRAIN) && !i_stall) begin
        tmo_cnt <= tmo_inc;
      end
      if (tmo_hit && !all_rcvd) begin
        o_timeout <= 1'b1;
      end
    end
  end

endmodule
